// File: rtl/rs_syndrome.sv
// rs_syndrome: serial Reed-Solomon syndrome accumulator over GF(2^8)/0x11d with serial unload
module rs_syndrome #(
    parameter int NSYM = 16,
    parameter int N    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       syn_valid,
    output logic [4:0] syn_index,
    output logic [7:0] syn_data,
    output logic       syn_last,
    output logic       syn_nonzero,
    output logic       len_err
);
    typedef enum logic {ACCUM, UNLOAD} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NSYM - 1);
    localparam logic [8:0] N9       = 9'(N);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
    endfunction

    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = xtime(r);
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] syn_q [NSYM];
    logic [7:0] syn_d [NSYM];
    logic [7:0] upd   [NSYM];
    logic [7:0] cnt_q, cnt_d;
    logic       in_ready_q, in_ready_d;
    logic       syn_valid_q, syn_valid_d;
    logic [4:0] syn_index_q, syn_index_d;
    logic [7:0] syn_data_q, syn_data_d;
    logic       syn_last_q, syn_last_d;
    logic       syn_nonzero_q, syn_nonzero_d;
    logic       len_err_q, len_err_d;
    logic       accept;
    logic       nz;
    logic [4:0] nxt;
    logic [7:0] sel;

    assign accept = in_valid & in_ready_q;
    assign nxt    = syn_index_q + 5'd1;

    // Horner step with a constant multiplier by alpha^j per syndrome
    for (genvar g = 0; g < NSYM; g++) begin : g_mul
        localparam logic [7:0] ALPHA = gf_pow(g);
        assign upd[g] = gf_mul(syn_q[g], ALPHA) ^ in_data;
    end

    // Nonzero flag over the post-update syndromes and the next unload mux
    always_comb begin
        nz  = 1'b0;
        sel = 8'h00;
        for (int j = 0; j < NSYM; j++) begin
            nz  = nz | (|upd[j]);
            sel = (nxt == 5'(j)) ? syn_q[j] : sel;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    // Next state: leave ACCUM on the accepted last byte, return after the final syndrome
    always_comb begin
        state_d = state_q;
        if (state_q == ACCUM && accept && in_last) state_d = UNLOAD;
        else if (state_q == UNLOAD && syn_last_q)  state_d = ACCUM;
    end

    // Datapath and registered outputs; S_0 is taken straight from the update so it appears one cycle after in_last
    always_comb begin
        syn_d         = syn_q;
        cnt_d         = cnt_q;
        in_ready_d    = in_ready_q;
        syn_valid_d   = 1'b0;
        syn_index_d   = syn_index_q;
        syn_data_d    = syn_data_q;
        syn_last_d    = 1'b0;
        syn_nonzero_d = syn_nonzero_q;
        len_err_d     = len_err_q;
        if (state_q == ACCUM && accept) begin
            syn_d = upd;
            cnt_d = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
            if (in_last) begin
                in_ready_d    = 1'b0;
                syn_valid_d   = 1'b1;
                syn_index_d   = 5'd0;
                syn_data_d    = upd[0];
                syn_nonzero_d = nz;
                len_err_d     = ({1'b0, cnt_q} + 9'd1) != N9;
            end
        end else if (state_q == UNLOAD) begin
            if (syn_last_q) begin
                for (int j = 0; j < NSYM; j++) syn_d[j] = 8'h00;
                cnt_d      = 8'h00;
                in_ready_d = 1'b1;
            end else begin
                syn_valid_d = 1'b1;
                syn_index_d = nxt;
                syn_data_d  = sel;
                syn_last_d  = nxt == LAST_IDX;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NSYM; j++) syn_q[j] <= 8'h00;
            cnt_q         <= 8'h00;
            in_ready_q    <= 1'b1;
            syn_valid_q   <= 1'b0;
            syn_index_q   <= 5'd0;
            syn_data_q    <= 8'h00;
            syn_last_q    <= 1'b0;
            syn_nonzero_q <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            syn_q         <= syn_d;
            cnt_q         <= cnt_d;
            in_ready_q    <= in_ready_d;
            syn_valid_q   <= syn_valid_d;
            syn_index_q   <= syn_index_d;
            syn_data_q    <= syn_data_d;
            syn_last_q    <= syn_last_d;
            syn_nonzero_q <= syn_nonzero_d;
            len_err_q     <= len_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign syn_valid   = syn_valid_q;
    assign syn_index   = syn_index_q;
    assign syn_data    = syn_data_q;
    assign syn_last    = syn_last_q;
    assign syn_nonzero = syn_nonzero_q;
    assign len_err     = len_err_q;
endmodule

// File: doc/rs_syndrome.md
# rs_syndrome

Serial Reed-Solomon syndrome calculator over GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11d), generator element alpha = 0x02, first consecutive root alpha^0. It accepts one received codeword byte per accepted cycle and accumulates NSYM syndromes S_j = r(alpha^j) in parallel by Horner's rule. It then streams the syndromes out one per cycle to the downstream key-equation solver. It sits at the head of the RS decoder, directly upstream of the log/antilog-table based error locator stages.

## Interface
- NSYM, 16, number of syndromes (2T); legal 2..32
- N, 255, codeword length in bytes; legal NSYM+1..255
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data valid this cycle
- in_data  in  8  received symbol; first byte is r_{N-1} (highest degree)
- in_last  in  1  marks final byte of codeword (r_0); qualified by in_valid
- in_ready  out  1  block accepts a byte when in_valid & in_ready
- syn_valid  out  1  syn_data valid this cycle
- syn_index  out  5  index j of syn_data
- syn_data  out  8  syndrome S_j
- syn_last  out  1  high with S_{NSYM-1}
- syn_nonzero  out  1  OR of all S_j ≠ 0; valid when syn_last=1
- len_err  out  1  byte count at in_last ≠ N; valid when syn_last=1

## Operation
- One clock; reset is synchronous and active-high.
- States: ACCUM, UNLOAD.
- ACCUM:
  - in_ready=1.
  - On each accepted byte, for all j in parallel: S_j <= gfmul(S_j, alpha^j) ^ in_data.
  - Byte counter cnt (8 bits) increments, saturating at 255.
  - First byte after entering ACCUM sees all S_j = 0, so S_j becomes in_data.
- Constant multipliers:
  - Combinational, derived from 0x11d reduction.
  - alpha^0..alpha^15 = 01,02,04,08,10,20,40,80,1d,3a,74,e8,cd,87,13,26.
  - Higher roots continue the same sequence, e.g. alpha^16=4c, alpha^31=c0.
- Accepted byte with in_last=1:
  - Update applied as usual.
  - Register len_err = (cnt+1 ≠ N).
  - Go to UNLOAD.
- UNLOAD:
  - in_ready=0.
  - Output S_0..S_{NSYM-1} on consecutive cycles, syn_valid=1 each cycle, syn_index=j.
  - No downstream backpressure; the consumer must accept every cycle.
  - After S_{NSYM-1}: clear all S_j and cnt to 0, return to ACCUM.
- in_valid=0 cycles in ACCUM: hold state, no update. Gaps are allowed anywhere in the codeword.
- in_valid during UNLOAD: ignored (in_ready=0); upstream must hold the byte.
- Codewords shorter than N: processed normally (treated as shortened code with leading zeros), len_err=1. Longer than N: cnt saturates, len_err=1.
- syn_nonzero: OR of all final S_j ≠ 0, computed at in_last acceptance and held through UNLOAD.

## Timing
- Reset values:
  - State ACCUM, all S_j=0, cnt=0.
  - in_ready=1 (first cycle after rst deasserts).
  - syn_valid=0, syn_index=0, syn_data=0, syn_last=0, syn_nonzero=0, len_err=0.
- rst asserted mid-ACCUM or mid-UNLOAD: next cycle is the reset state. A partial codeword is discarded and any unload in progress is aborted (syn_valid=0).
- Latency: in_last accepted at cycle t -> S_0 at t+1, S_{NSYM-1} with syn_last at t+NSYM.
- in_ready=0 for cycles t+1..t+NSYM; in_ready=1 at t+NSYM+1. Back-to-back throughput is N+NSYM cycles per codeword.
- All outputs are registered; no combinational path from inputs to outputs.
- syn_index, syn_data, syn_nonzero and len_err are don't-care-free: they hold their last value while syn_valid=0.

## Test plan
- 255 bytes of 0x00, in_last on the 255th -> 16 syndromes all 00, syn_nonzero=0, len_err=0; S_0 one cycle after in_last, in_ready low for 16 cycles.
- 254×00 then 01 -> every S_j = 01, syn_nonzero=1.
- 253×00, 01, 00 -> S_0..S_15 = 01,02,04,08,10,20,40,80,1d,3a,74,e8,cd,87,13,26.
- Same stimulus as the previous scenario with random in_valid gaps, plus in_valid held high during UNLOAD -> identical syndromes; no byte lost or duplicated.
- Codeword with in_last on byte 10 -> len_err=1, syndromes match the software model of a zero-padded word; next 255-byte codeword -> len_err=0.
- rst pulsed after 100 bytes, then a clean 255-byte valid RS codeword -> all syndromes 00, syn_nonzero=0. Also: rst pulsed during UNLOAD at j=5 -> syn_valid=0 next cycle, in_ready=1.
